// File: rtl/decode_execute_register.sv
// Decode-to-execute pipeline register with stall hold, flush bubbles, a valid
// bit and a saturating bubble counter.
module decode_execute_register #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned VEC_WIDTH      = 128,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic                      ValidD,
  input  logic                      PCSrcD,
  input  logic                      RegWriteD,
  input  logic                      RegWriteVD,
  input  logic                      MemtoRegD,
  input  logic                      MemWriteD,
  input  logic                      MemSrcD,
  input  logic                      MemDataD,
  input  logic                      VecDataD,
  input  logic                      BranchD,
  input  logic                      ALUSrcD,
  input  logic [2:0]                ALUControlD,
  input  logic [1:0]                FlagWriteD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [VEC_WIDTH-1:0]      VRD1D,
  input  logic [VEC_WIDTH-1:0]      VRD2D,
  input  logic [DATA_WIDTH-1:0]     ExtImmD,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  output logic                      PCSrcE,
  output logic                      RegWriteE,
  output logic                      RegWriteVE,
  output logic                      MemtoRegE,
  output logic                      MemWriteE,
  output logic                      MemSrcE,
  output logic                      MemDataE,
  output logic                      VecDataE,
  output logic                      BranchE,
  output logic                      ALUSrcE,
  output logic [2:0]                ALUControlE,
  output logic [1:0]                FlagWriteE,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [VEC_WIDTH-1:0]      VRD1E,
  output logic [VEC_WIDTH-1:0]      VRD2E,
  output logic [DATA_WIDTH-1:0]     ExtImmE,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      ValidE,
  output logic [CNT_WIDTH-1:0]      BubbleCount
);

  typedef struct packed {
    logic       pc_src;
    logic       reg_write;
    logic       reg_write_v;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_src;
    logic       mem_data;
    logic       vec_data;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_control;
    logic [1:0] flag_write;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [VEC_WIDTH-1:0]      vrd1;
    logic [VEC_WIDTH-1:0]      vrd2;
    logic [DATA_WIDTH-1:0]     ext_imm;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } data_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  ctrl_t                ctrl_in_c;
  data_t                data_in_c;
  ctrl_t                ctrl_d, ctrl_q;
  data_t                data_d, data_q;
  logic                 valid_d, valid_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 bubble_c;

  assign ctrl_in_c = '{pc_src: PCSrcD, reg_write: RegWriteD, reg_write_v: RegWriteVD,
                       mem_to_reg: MemtoRegD, mem_write: MemWriteD, mem_src: MemSrcD,
                       mem_data: MemDataD, vec_data: VecDataD, branch: BranchD,
                       alu_src: ALUSrcD, alu_control: ALUControlD, flag_write: FlagWriteD};
  assign data_in_c = '{rd1: RD1D, rd2: RD2D, vrd1: VRD1D, vrd2: VRD2D,
                       ext_imm: ExtImmD, rd: RdD};

  // Next-state: flush beats stall beats load; an invalid slot loads as a control-free bubble.
  always_comb begin
    ctrl_d   = ctrl_q;
    data_d   = data_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    bubble_c = 1'b0;
    if (FlushE) begin
      ctrl_d   = '0;
      data_d   = '0;
      valid_d  = 1'b0;
      bubble_c = 1'b1;
    end else if (!StallE) begin
      data_d   = data_in_c;
      valid_d  = ValidD;
      ctrl_d   = ValidD ? ctrl_in_c : '0;
      bubble_c = !ValidD;
    end
    if (bubble_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCSrcE      = ctrl_q.pc_src;
  assign RegWriteE   = ctrl_q.reg_write;
  assign RegWriteVE  = ctrl_q.reg_write_v;
  assign MemtoRegE   = ctrl_q.mem_to_reg;
  assign MemWriteE   = ctrl_q.mem_write;
  assign MemSrcE     = ctrl_q.mem_src;
  assign MemDataE    = ctrl_q.mem_data;
  assign VecDataE    = ctrl_q.vec_data;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ALUControlE = ctrl_q.alu_control;
  assign FlagWriteE  = ctrl_q.flag_write;
  assign RD1E        = data_q.rd1;
  assign RD2E        = data_q.rd2;
  assign VRD1E       = data_q.vrd1;
  assign VRD2E       = data_q.vrd2;
  assign ExtImmE     = data_q.ext_imm;
  assign RdE         = data_q.rd;
  assign ValidE      = valid_q;
  assign BubbleCount = cnt_q;

endmodule

// File: tb/tb_decode_execute_register.sv
// Self-checking bench for decode_execute_register: directed scenarios plus a
// randomized run against a field-level reference model.
`timescale 1ns/1ps
module tb_decode_execute_register;

  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic       pc_src, reg_write, reg_write_v, mem_to_reg, mem_write;
    logic       mem_src, mem_data, vec_data, branch, alu_src;
    logic [2:0] alu_control;
    logic [1:0] flag_write;
  } ctrl_t;

  typedef struct packed {
    ctrl_t        c;
    logic [31:0]  rd1, rd2;
    logic [127:0] vrd1, vrd2;
    logic [31:0]  ext_imm;
    logic [4:0]   rd;
  } fields_t;

  logic clk = 1'b0;
  logic rst, stall, flush, valid_d;
  fields_t din, eout;

  logic e_pc_src, e_reg_write, e_reg_write_v, e_mem_to_reg, e_mem_write;
  logic e_mem_src, e_mem_data, e_vec_data, e_branch, e_alu_src;
  logic [2:0] e_alu_control;
  logic [1:0] e_flag_write;
  logic [31:0] e_rd1, e_rd2, e_ext_imm;
  logic [127:0] e_vrd1, e_vrd2;
  logic [4:0] e_rd;
  logic e_valid;
  logic [CW-1:0] e_cnt;

  // Reference state
  fields_t exp_e = '0;
  logic    exp_valid = 1'b0;
  int      exp_cnt = 0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign eout = {e_pc_src, e_reg_write, e_reg_write_v, e_mem_to_reg, e_mem_write,
                 e_mem_src, e_mem_data, e_vec_data, e_branch, e_alu_src,
                 e_alu_control, e_flag_write, e_rd1, e_rd2, e_vrd1, e_vrd2,
                 e_ext_imm, e_rd};

  decode_execute_register #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .StallE(stall), .FlushE(flush), .ValidD(valid_d),
    .PCSrcD(din.c.pc_src), .RegWriteD(din.c.reg_write), .RegWriteVD(din.c.reg_write_v),
    .MemtoRegD(din.c.mem_to_reg), .MemWriteD(din.c.mem_write), .MemSrcD(din.c.mem_src),
    .MemDataD(din.c.mem_data), .VecDataD(din.c.vec_data), .BranchD(din.c.branch),
    .ALUSrcD(din.c.alu_src), .ALUControlD(din.c.alu_control), .FlagWriteD(din.c.flag_write),
    .RD1D(din.rd1), .RD2D(din.rd2), .VRD1D(din.vrd1), .VRD2D(din.vrd2),
    .ExtImmD(din.ext_imm), .RdD(din.rd),
    .PCSrcE(e_pc_src), .RegWriteE(e_reg_write), .RegWriteVE(e_reg_write_v),
    .MemtoRegE(e_mem_to_reg), .MemWriteE(e_mem_write), .MemSrcE(e_mem_src),
    .MemDataE(e_mem_data), .VecDataE(e_vec_data), .BranchE(e_branch),
    .ALUSrcE(e_alu_src), .ALUControlE(e_alu_control), .FlagWriteE(e_flag_write),
    .RD1E(e_rd1), .RD2E(e_rd2), .VRD1E(e_vrd1), .VRD2E(e_vrd2),
    .ExtImmE(e_ext_imm), .RdE(e_rd), .ValidE(e_valid), .BubbleCount(e_cnt)
  );

  // One rising edge: update the reference from the sampled inputs, then settle.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      exp_e = '0; exp_valid = 1'b0; exp_cnt = 0;
    end else if (flush) begin
      exp_e = '0; exp_valid = 1'b0;
      exp_cnt = (exp_cnt + 1 > CNT_MAX) ? CNT_MAX : exp_cnt + 1;
    end else if (!stall) begin
      exp_e = din;
      exp_valid = valid_d;
      if (!valid_d) begin
        exp_e.c = '0;
        exp_cnt = (exp_cnt + 1 > CNT_MAX) ? CNT_MAX : exp_cnt + 1;
      end
    end
    #1;
  endtask

  task automatic rand_din();
    din.c       = ctrl_t'($urandom);
    din.rd1     = $urandom;
    din.rd2     = $urandom;
    din.vrd1    = {$urandom, $urandom, $urandom, $urandom};
    din.vrd2    = {$urandom, $urandom, $urandom, $urandom};
    din.ext_imm = $urandom;
    din.rd      = 5'($urandom);
  endtask

  task automatic test_reset();
    din = '1; valid_d = 1'b1; stall = 1'b1; flush = 1'b0; rst = 1'b1;
    step(); step();
    checks++; if (eout !== '0) $display("FAIL reset_fields got=%h want=0", eout); else passed++;
    checks++; if (e_valid !== 1'b0 || e_cnt !== '0)
      $display("FAIL reset_valid_cnt got=%b/%0d want=0/0", e_valid, e_cnt); else passed++;
    rst = 1'b0; stall = 1'b0; din = '0;
    din.rd1 = 32'h0000_00A5; din.c.alu_control = 3'b010; din.c.reg_write = 1'b1;
    step();
    checks++; if (e_rd1 !== 32'h0000_00A5 || e_alu_control !== 3'b010 || e_reg_write !== 1'b1 || e_valid !== 1'b1)
      $display("FAIL first_load got rd1=%h alu=%b rw=%b v=%b want a5/010/1/1",
               e_rd1, e_alu_control, e_reg_write, e_valid); else passed++;
  endtask

  task automatic test_stall();
    logic [127:0] v;
    v = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    din.rd = 5'd7; din.vrd1 = v;
    step();
    stall = 1'b1; din.rd = 5'd9; din.vrd1 = ~v;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (e_rd !== 5'd7 || e_vrd1 !== v || e_cnt !== 4'd0)
        $display("FAIL stall_hold cyc=%0d got rd=%0d vrd1=%h cnt=%0d want 7/%h/0", i, e_rd, e_vrd1, e_cnt, v);
      else passed++;
    end
    stall = 1'b0;
    step();
    checks++; if (e_rd !== 5'd9) $display("FAIL stall_release got rd=%0d want 9", e_rd); else passed++;
  endtask

  task automatic test_flush();
    din.c.mem_write = 1'b1; din.c.flag_write = 2'b11;
    step();
    checks++; if (e_mem_write !== 1'b1 || e_flag_write !== 2'b11)
      $display("FAIL flush_preload got mw=%b fw=%b want 1/11", e_mem_write, e_flag_write); else passed++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (eout !== '0 || e_valid !== 1'b0 || e_cnt !== 4'd1)
      $display("FAIL flush_bubble got=%h v=%b cnt=%0d want 0/0/1", eout, e_valid, e_cnt); else passed++;
  endtask

  task automatic test_flush_stall();
    rand_din();
    step();
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    checks++; if (eout !== '0 || e_valid !== 1'b0 || e_cnt !== 4'd2)
      $display("FAIL flush_stall got=%h v=%b cnt=%0d want 0/0/2", eout, e_valid, e_cnt); else passed++;
  endtask

  task automatic test_invalid();
    rand_din();
    valid_d = 1'b0; din.c.reg_write_v = 1'b1; din.c.mem_write = 1'b1; din.rd2 = 32'hDEAD_BEEF;
    step();
    valid_d = 1'b1;
    checks++; if (e_reg_write_v !== 1'b0 || e_mem_write !== 1'b0 || e_rd2 !== 32'hDEAD_BEEF ||
                  e_valid !== 1'b0 || e_cnt !== 4'd3)
      $display("FAIL invalid_slot got rwv=%b mw=%b rd2=%h v=%b cnt=%0d want 0/0/deadbeef/0/3",
               e_reg_write_v, e_mem_write, e_rd2, e_valid, e_cnt); else passed++;
    checks++; if (eout.c !== '0) $display("FAIL invalid_ctrl got=%h want 0", eout.c); else passed++;
  endtask

  task automatic test_saturation_reset();
    flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_din();
      step();
      checks++; if (int'(e_cnt) !== exp_cnt)
        $display("FAIL sat_count cyc=%0d got=%0d want=%0d", i, e_cnt, exp_cnt); else passed++;
    end
    checks++; if (e_cnt !== 4'd15) $display("FAIL sat_final got=%0d want 15", e_cnt); else passed++;
    flush = 1'b0; stall = 1'b0; rand_din();
    step();
    stall = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    checks++; if (eout !== '0 || e_valid !== 1'b0 || e_cnt !== '0)
      $display("FAIL reset_in_stall got=%h v=%b cnt=%0d want 0/0/0", eout, e_valid, e_cnt); else passed++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      rand_din();
      rst     = ($urandom_range(0, 49) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 5) == 0);
      valid_d = ($urandom_range(0, 4) != 0);
      step();
      checks++;
      if (eout !== exp_e || e_valid !== exp_valid || int'(e_cnt) !== exp_cnt) begin
        if (errs < 10)
          $display("FAIL random cyc=%0d got=%h v=%b cnt=%0d want=%h v=%b cnt=%0d",
                   i, eout, e_valid, e_cnt, exp_e, exp_valid, exp_cnt);
        errs++;
      end else passed++;
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0; valid_d = 1'b1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_d = 1'b1; din = '0;
    test_reset();
    test_stall();
    test_flush();
    test_flush_stall();
    test_invalid();
    test_saturation_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
